controller_l2: RTL and testbench

CONTROLLER_L2 -- requirements
Module: controller_l2

---
 rtl/controller_l2_pkg.sv | 27 ++
 rtl/controller_l2_counter_en.sv | 48 ++++
 rtl/controller_l2.sv | 221 ++++++++++++++++++++++
 tb/tb_controller_l2.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_l2_pkg.sv
// Shared definitions for the layer-2 controller blocks.
// Holds the FSM state encoding, the number of filter slots and the
// default geometry of the layer-2 run. No ports.
package controller_l2_pkg;

    localparam int DEF_FILTER_WORDS = 9;
    localparam int DEF_BUFF_WORDS   = 64;
    localparam int DEF_WIN_WORDS    = 9;
    localparam int DEF_MAC_STEPS    = 9;
    localparam int DEF_STRIDE       = 1;
    localparam int DEF_OFM_DEPTH    = 36;

    // Filter memory slots, selected one-hot by wEnFilter.
    localparam int FILTER_SLOTS     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILTER,
        S_LOAD_BUFF,
        S_WIN_RST,
        S_WIN_LOAD,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/controller_l2_counter_en.sv
// Generic enabled counter used for every layer-2 controller count.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   en_i      - advance by STEP (wraps to 0 after reaching MAX)
//   clr_i     - synchronous clear, has priority over en_i
//   cnt_o     - current count
//   tc_o      - terminal-count flag (cnt_o == MAX)
module counter_en
    import controller_l2_pkg::*;
#(
    parameter int W    = 6,
    parameter int MAX  = 1,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == W'(MAX));
    assign cnt_o = cnt_q;

    // With STEP > 1 the count may never land on MAX; it then simply
    // wraps modulo 2**W, which is what the window base pointer needs.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/controller_l2.sv
// Layer-2 convolution controller: loads four kernel slots and the input
// buffer from the layer-1 ofm memories, then for every output pixel resets
// and fills the window, runs the MAC and writes one ofm word.
// Ports:
//   clk, rst (async, active-low), start (run request), in_valid (source word valid)
//   busy, done               - run status / one-cycle completion pulse
//   src_addr                 - layer-1 ofm read address, advances per accepted word
//   wEnFilter, filterCount   - kernel slot write (one-hot) and word index
//   wEnBuff, buffAddress     - buffer write / buffer read address for the window
//   winRst, writeEnwindow    - window clear / window load
//   readEnmac, addEn, macCount - MAC strobes and step index
//   wrofm, ofmaddr           - ofm write strobe and address
// Strobes and their index outputs are registered: each describes the action
// the FSM performed in the previous cycle, so index and strobe always align.
module controller_l2
    import controller_l2_pkg::*;
#(
    parameter int FILTER_WORDS = DEF_FILTER_WORDS,
    parameter int BUFF_WORDS   = DEF_BUFF_WORDS,
    parameter int WIN_WORDS    = DEF_WIN_WORDS,
    parameter int MAC_STEPS    = DEF_MAC_STEPS,
    parameter int STRIDE       = DEF_STRIDE,
    parameter int OFM_DEPTH    = DEF_OFM_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] src_addr,
    output logic       wEnBuff,
    output logic       writeEnwindow,
    output logic       readEnmac,
    output logic       addEn,
    output logic       winRst,
    output logic       wrofm,
    output logic [5:0] filterCount,
    output logic [5:0] macCount,
    output logic [5:0] buffAddress,
    output logic [7:0] ofmaddr,
    output logic [3:0] wEnFilter
);

    state_t state_q, state_d;

    logic       busy_q, busy_d, done_q, done_d;
    logic       wEnBuff_q, wEnBuff_d, writeEnwindow_q, writeEnwindow_d;
    logic       readEnmac_q, readEnmac_d, addEn_q, addEn_d;
    logic       winRst_q, winRst_d, wrofm_q, wrofm_d;
    logic [5:0] filterCount_q, filterCount_d, macCount_q, macCount_d;
    logic [5:0] buffAddress_q, buffAddress_d;
    logic [7:0] ofmaddr_q, ofmaddr_d;
    logic [3:0] wEnFilter_q, wEnFilter_d;

    logic [5:0] fcnt, bcnt, wcnt, mcnt, base;
    logic [1:0] slot;
    logic [7:0] src, ocnt;
    logic       fcnt_tc, slot_tc, bcnt_tc, wcnt_tc, mcnt_tc, ocnt_tc;
    logic       src_tc, base_tc;
    logic       unused_tc;

    logic run_clr, in_lf, in_lb, in_wl, in_mac, in_wr;

    assign run_clr = (state_q == S_IDLE) && start;
    assign in_lf   = (state_q == S_LOAD_FILTER);
    assign in_lb   = (state_q == S_LOAD_BUFF);
    assign in_wl   = (state_q == S_WIN_LOAD);
    assign in_mac  = (state_q == S_MAC);
    assign in_wr   = (state_q == S_WRITE);

    assign unused_tc = src_tc ^ base_tc;

    counter_en #(.W(6), .MAX(FILTER_WORDS-1), .STEP(1)) u_fcnt (
        .clk(clk), .rst(rst), .en_i(in_lf && in_valid), .clr_i(run_clr),
        .cnt_o(fcnt), .tc_o(fcnt_tc));

    counter_en #(.W(2), .MAX(FILTER_SLOTS-1), .STEP(1)) u_slot (
        .clk(clk), .rst(rst), .en_i(in_lf && in_valid && fcnt_tc), .clr_i(run_clr),
        .cnt_o(slot), .tc_o(slot_tc));

    counter_en #(.W(6), .MAX(BUFF_WORDS-1), .STEP(1)) u_bcnt (
        .clk(clk), .rst(rst), .en_i(in_lb && in_valid), .clr_i(run_clr),
        .cnt_o(bcnt), .tc_o(bcnt_tc));

    counter_en #(.W(8), .MAX(255), .STEP(1)) u_src (
        .clk(clk), .rst(rst), .en_i((in_lf || in_lb) && in_valid), .clr_i(run_clr),
        .cnt_o(src), .tc_o(src_tc));

    counter_en #(.W(6), .MAX(WIN_WORDS-1), .STEP(1)) u_wcnt (
        .clk(clk), .rst(rst), .en_i(in_wl), .clr_i(run_clr),
        .cnt_o(wcnt), .tc_o(wcnt_tc));

    counter_en #(.W(6), .MAX(MAC_STEPS-1), .STEP(1)) u_mcnt (
        .clk(clk), .rst(rst), .en_i(in_mac), .clr_i(run_clr),
        .cnt_o(mcnt), .tc_o(mcnt_tc));

    counter_en #(.W(8), .MAX(OFM_DEPTH-1), .STEP(1)) u_ocnt (
        .clk(clk), .rst(rst), .en_i(in_wr), .clr_i(run_clr),
        .cnt_o(ocnt), .tc_o(ocnt_tc));

    // Window base: MAX at the 6-bit ceiling so it wraps modulo 64.
    counter_en #(.W(6), .MAX(63), .STEP(STRIDE)) u_base (
        .clk(clk), .rst(rst), .en_i(in_wr), .clr_i(run_clr),
        .cnt_o(base), .tc_o(base_tc));

    always_comb begin
        state_d         = state_q;
        wEnFilter_d     = '0;
        wEnBuff_d       = 1'b0;
        writeEnwindow_d = 1'b0;
        readEnmac_d     = 1'b0;
        addEn_d         = 1'b0;
        winRst_d        = 1'b0;
        wrofm_d         = 1'b0;
        filterCount_d   = '0;
        macCount_d      = '0;
        buffAddress_d   = '0;
        ofmaddr_d       = ocnt;
        done_d          = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_FILTER;
            end
            S_LOAD_FILTER: begin
                filterCount_d = filterCount_q;
                if (in_valid) begin
                    wEnFilter_d   = 4'b0001 << slot;
                    filterCount_d = fcnt;
                    if (fcnt_tc && slot_tc) state_d = S_LOAD_BUFF;
                end
            end
            S_LOAD_BUFF: begin
                buffAddress_d = buffAddress_q;
                if (in_valid) begin
                    wEnBuff_d     = 1'b1;
                    buffAddress_d = bcnt;
                    if (bcnt_tc) state_d = S_WIN_RST;
                end
            end
            S_WIN_RST: begin
                winRst_d = 1'b1;
                state_d  = S_WIN_LOAD;
            end
            S_WIN_LOAD: begin
                writeEnwindow_d = 1'b1;
                buffAddress_d   = base + wcnt;
                if (wcnt_tc) state_d = S_MAC;
            end
            S_MAC: begin
                readEnmac_d = 1'b1;
                addEn_d     = 1'b1;
                macCount_d  = mcnt;
                if (mcnt_tc) state_d = S_WRITE;
            end
            S_WRITE: begin
                wrofm_d = 1'b1;
                state_d = ocnt_tc ? S_DONE : S_WIN_RST;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            wEnFilter_q     <= '0;
            wEnBuff_q       <= 1'b0;
            writeEnwindow_q <= 1'b0;
            readEnmac_q     <= 1'b0;
            addEn_q         <= 1'b0;
            winRst_q        <= 1'b0;
            wrofm_q         <= 1'b0;
            filterCount_q   <= '0;
            macCount_q      <= '0;
            buffAddress_q   <= '0;
            ofmaddr_q       <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            wEnFilter_q     <= wEnFilter_d;
            wEnBuff_q       <= wEnBuff_d;
            writeEnwindow_q <= writeEnwindow_d;
            readEnmac_q     <= readEnmac_d;
            addEn_q         <= addEn_d;
            winRst_q        <= winRst_d;
            wrofm_q         <= wrofm_d;
            filterCount_q   <= filterCount_d;
            macCount_q      <= macCount_d;
            buffAddress_q   <= buffAddress_d;
            ofmaddr_q       <= ofmaddr_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign src_addr      = src;
    assign wEnFilter     = wEnFilter_q;
    assign wEnBuff       = wEnBuff_q;
    assign writeEnwindow = writeEnwindow_q;
    assign readEnmac     = readEnmac_q;
    assign addEn         = addEn_q;
    assign winRst        = winRst_q;
    assign wrofm         = wrofm_q;
    assign filterCount   = filterCount_q;
    assign macCount      = macCount_q;
    assign buffAddress   = buffAddress_q;
    assign ofmaddr       = ofmaddr_q;

endmodule

// File: tb/tb_controller_l2.sv
// Bench for controller_l2: a reference model expands each run into the
// ordered list of datapath events it must produce; a monitor pops and
// compares every event the DUT presents.
module tb_controller_l2;

    localparam int FW    = 9;
    localparam int BW    = 64;
    localparam int WW    = 9;
    localparam int MS    = 9;
    localparam int SLOTS = 4;
    localparam int PIX_LAT = 1 + WW + MS + 1;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    localparam int K_FILT = 1, K_BUFF = 2, K_WRST = 3, K_WIN = 4,
                   K_MAC = 5, K_OFM = 6, K_DONE = 7;

    logic clk = 1'b0;
    logic rst, start, start2, in_valid;

    logic       busy, done, wEnBuff, writeEnwindow, readEnmac, addEn, winRst, wrofm;
    logic [7:0] src_addr, ofmaddr;
    logic [5:0] filterCount, macCount, buffAddress;
    logic [3:0] wEnFilter;

    logic       d2_busy, d2_done, d2_wEnBuff, d2_writeEnwindow, d2_readEnmac, d2_addEn;
    logic       d2_winRst, d2_wrofm;
    logic [7:0] d2_src_addr, d2_ofmaddr;
    logic [5:0] d2_filterCount, d2_macCount, d2_buffAddress;
    logic [3:0] d2_wEnFilter;

    logic [45:0] all1;
    assign all1 = {busy, done, src_addr, wEnBuff, writeEnwindow, readEnmac, addEn,
                   winRst, wrofm, filterCount, macCount, buffAddress, ofmaddr, wEnFilter};

    ev_t q1[$];
    ev_t q2[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  last_wr = -1;
    int  busy_cyc = 0;
    int  done_cnt = 0;

    always #5 clk = ~clk;

    controller_l2 dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .busy(busy), .done(done), .src_addr(src_addr),
        .wEnBuff(wEnBuff), .writeEnwindow(writeEnwindow), .readEnmac(readEnmac),
        .addEn(addEn), .winRst(winRst), .wrofm(wrofm),
        .filterCount(filterCount), .macCount(macCount), .buffAddress(buffAddress),
        .ofmaddr(ofmaddr), .wEnFilter(wEnFilter));

    controller_l2 #(.STRIDE(8), .OFM_DEPTH(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
        .busy(d2_busy), .done(d2_done), .src_addr(d2_src_addr),
        .wEnBuff(d2_wEnBuff), .writeEnwindow(d2_writeEnwindow), .readEnmac(d2_readEnmac),
        .addEn(d2_addEn), .winRst(d2_winRst), .wrofm(d2_wrofm),
        .filterCount(d2_filterCount), .macCount(d2_macCount), .buffAddress(d2_buffAddress),
        .ofmaddr(d2_ofmaddr), .wEnFilter(d2_wEnFilter));

    task automatic push(input int which, input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        if (which == 1) q1.push_back(e);
        else            q2.push_back(e);
    endtask

    // Reference model: the full event list for one run.
    task automatic gen_run(input int which, input int stride, input int depth);
        int b;
        b = 0;
        for (int s = 0; s < SLOTS; s++)
            for (int k = 0; k < FW; k++)
                push(which, K_FILT, (1 << s) * 64 + k);
        for (int a = 0; a < BW; a++) push(which, K_BUFF, a);
        for (int p = 0; p < depth; p++) begin
            push(which, K_WRST, 0);
            for (int i = 0; i < WW; i++) push(which, K_WIN, (b + i) % 64);
            for (int m = 0; m < MS; m++) push(which, K_MAC, m);
            push(which, K_OFM, p);
            b = (b + stride) % 64;
        end
        push(which, K_DONE, 0);
    endtask

    task automatic sb_take(input int which, input int kind, input int val, input string name);
        ev_t e;
        int  sz;
        vectors++;
        sz = (which == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            miscompares++;
            $display("FAIL %s dut%0d: got unexpected event value %0d, required no event", name, which, val);
            return;
        end
        if (which == 1) e = q1.pop_front();
        else            e = q2.pop_front();
        if (e.kind != kind || e.val != val) begin
            miscompares++;
            $display("FAIL %s dut%0d: got kind %0d value %0d, required kind %0d value %0d",
                     name, which, kind, val, e.kind, e.val);
        end
    endtask

    task automatic check_strobes(input int which, input logic [3:0] wf, input logic wb,
                                 input logic wr, input logic wl, input logic rm,
                                 input logic ae, input logic wo, input logic bz);
        int n;
        n = int'(wf != 0) + int'(wb) + int'(wr) + int'(wl) + int'(rm | ae) + int'(wo);
        if (n > 0) begin
            vectors++;
            if (n > 1 || rm != ae || (wf & (wf - 4'd1)) != 0 || !bz) begin
                miscompares++;
                $display("FAIL strobe_excl dut%0d: got %0d strobes wEnFilter=%b busy=%b, required one strobe, one-hot, busy=1",
                         which, n, wf, bz);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check_strobes(1, wEnFilter, wEnBuff, winRst, writeEnwindow, readEnmac, addEn, wrofm, busy);
            if (wEnFilter != 0) sb_take(1, K_FILT, int'(wEnFilter) * 64 + int'(filterCount), "filter_write");
            if (wEnBuff)        sb_take(1, K_BUFF, int'(buffAddress), "buff_write");
            if (winRst)         sb_take(1, K_WRST, 0, "win_rst");
            if (writeEnwindow)  sb_take(1, K_WIN, int'(buffAddress), "win_load");
            if (readEnmac)      sb_take(1, K_MAC, int'(macCount), "mac_step");
            if (wrofm) begin
                sb_take(1, K_OFM, int'(ofmaddr), "ofm_write");
                if (last_wr >= 0) begin
                    vectors++;
                    if (cyc - last_wr != PIX_LAT) begin
                        miscompares++;
                        $display("FAIL pixel_latency: got %0d cycles, required %0d", cyc - last_wr, PIX_LAT);
                    end
                end
                last_wr = cyc;
            end
            if (done) begin
                sb_take(1, K_DONE, 0, "done");
                done_cnt++;
                last_wr = -1;
            end
            if (busy) busy_cyc++;

            check_strobes(2, d2_wEnFilter, d2_wEnBuff, d2_winRst, d2_writeEnwindow, d2_readEnmac,
                          d2_addEn, d2_wrofm, d2_busy);
            if (d2_wEnFilter != 0) sb_take(2, K_FILT, int'(d2_wEnFilter) * 64 + int'(d2_filterCount), "filter_write");
            if (d2_wEnBuff)        sb_take(2, K_BUFF, int'(d2_buffAddress), "buff_write");
            if (d2_winRst)         sb_take(2, K_WRST, 0, "win_rst");
            if (d2_writeEnwindow)  sb_take(2, K_WIN, int'(d2_buffAddress), "win_load");
            if (d2_readEnmac)      sb_take(2, K_MAC, int'(d2_macCount), "mac_step");
            if (d2_wrofm)          sb_take(2, K_OFM, int'(d2_ofmaddr), "ofm_write");
            if (d2_done)           sb_take(2, K_DONE, 0, "done");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (all1 != '0) begin
            miscompares++;
            $display("FAIL %s: outputs got %h, required all zero", name, all1);
        end
    endtask

    task automatic wait_empty(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        repeat (5) step();
        check_val("run_complete_pending", (which == 1) ? q1.size() : q2.size(), 0);
        if (which == 1) q1.delete();
        else            q2.delete();
    endtask

    task automatic pulse(input int which);
        if (which == 1) start = 1'b1;
        else            start2 = 1'b1;
        step();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    initial begin
        int n, d0;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
        #1 rst = 1'b0;
        #1 check_zero("reset_state");
        repeat (3) step();
        check_zero("reset_held");
        rst = 1'b1;
        repeat (5) step();
        check_zero("after_release");

        // Continuous in_valid at defaults.
        in_valid = 1'b1;
        gen_run(1, 1, 36);
        busy_cyc = 0;
        pulse(1);
        wait_empty(1, 2000);
        check_val("busy_cycles", busy_cyc, SLOTS * FW + BW + 36 * PIX_LAT + 1);
        check_val("src_addr_end", int'(src_addr), 100);

        // Random stalls during the load phases.
        gen_run(1, 1, 36);
        pulse(1);
        n = 0;
        while (busy && n < 5000) begin
            in_valid = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        in_valid = 1'b1;
        wait_empty(1, 2000);
        check_val("src_addr_stall", int'(src_addr), 100);

        // start pulses while busy are ignored.
        gen_run(1, 1, 36);
        d0 = done_cnt;
        pulse(1);
        n = 0;
        while (busy && n < 3000) begin
            start = ($urandom_range(0, 9) == 0);
            step();
            n++;
        end
        start = 1'b0;
        wait_empty(1, 2000);
        check_val("done_count", done_cnt - d0, 1);

        // Asynchronous reset in the middle of MAC.
        gen_run(1, 1, 36);
        pulse(1);
        n = 0;
        while (!readEnmac && n < 3000) begin
            step();
            n++;
        end
        check_val("reach_mac", int'(readEnmac), 1);
        #1 rst = 1'b0;
        q1.delete();
        last_wr = -1;
        #1 check_zero("reset_mid_mac");
        step();
        check_zero("reset_mid_mac_held");
        rst = 1'b1;
        repeat (10) step();
        check_zero("idle_after_reset");
        gen_run(1, 1, 36);
        pulse(1);
        wait_empty(1, 2000);
        check_val("src_addr_rerun", int'(src_addr), 100);

        // STRIDE=8, OFM_DEPTH=8: window base wraps on the last pixel.
        gen_run(2, 8, 8);
        pulse(2);
        wait_empty(2, 1000);
        check_val("d2_src_addr_end", int'(d2_src_addr), 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
